polyveck_power2round_seq: RTL and testbench

- Sequential controller that applies Dilithium Power2Round (D = 13) to a K-polynomial vector t held in a single-port coefficient RAM.
- Streams LANES coefficients per cycle and writes the high part (t1) and low part (t0) into two separate result RAMs.
- Replaces the fully parallel vector-wide combinational array with a time-multiplexed LANES-wide datapath.
- Sits in key generation between the t = A·s1 + s2 stage and the t1 packing stage.

---
 rtl/polyveck_power2round_seq.sv | 150 +++++++++++++++
 tb/tb_polyveck_power2round_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/polyveck_power2round_seq.sv
// Power2Round (D bits) over a K-polynomial vector, LANES coefficients per cycle, 3-stage pipeline.
// Optional sticky input range flag: define P2R_RANGE_CHECK_EN to add the range_err output.
module polyveck_power2round_seq #(
  parameter int unsigned K      = 6,
  parameter int unsigned N      = 256,
  parameter int unsigned LANES  = 4,
  parameter int unsigned COEF_W = 32,
  parameter int unsigned D      = 13,
  parameter int unsigned ADDR_W = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [LANES*COEF_W-1:0]   rd_data,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [LANES*COEF_W-1:0]   t1_data,
  output logic [LANES*COEF_W-1:0]   t0_data
`ifdef P2R_RANGE_CHECK_EN
  ,
  output logic                      range_err
`endif
);

  localparam int unsigned W = K * N / LANES;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(W - 1);
  localparam logic signed [COEF_W-1:0] RND = COEF_W'((1 << (D - 1)) - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         rd_addr_q;
  logic                      s1_valid_q;
  logic [ADDR_W-1:0]         s1_addr_q;
  logic                      wr_en_q;
  logic [ADDR_W-1:0]         wr_addr_q;
  logic [LANES*COEF_W-1:0]   t1_q, t1_d;
  logic [LANES*COEF_W-1:0]   t0_q, t0_d;
  logic                      start_ok;

  function automatic logic signed [COEF_W-1:0] p2r_hi(input logic signed [COEF_W-1:0] a);
    logic signed [COEF_W-1:0] s;
    s = a + RND;
    return s >>> D;
  endfunction

  assign start_ok = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (rd_addr_q == LAST) state_d = ST_DRAIN;
      ST_DRAIN: if (wr_en_q && (wr_addr_q == LAST)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state_q == ST_RUN);
    busy  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done  = (state_q == ST_DONE);
  end

  // Read counter parks at 0 once the last word is issued, so idle rd_addr reads 0.
  always_ff @(posedge clk) begin
    if (rst)                   rd_addr_q <= '0;
    else if (state_q == ST_RUN) rd_addr_q <= (rd_addr_q == LAST) ? '0 : rd_addr_q + 1'b1;
  end

  // Stage 1: address/valid aligned with the RAM's 1-cycle read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
    end else begin
      s1_valid_q <= rd_en;
      s1_addr_q  <= rd_addr_q;
    end
  end

  always_comb begin
    t1_d = '0;
    t0_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      t1_d[COEF_W*i +: COEF_W] = p2r_hi(rd_data[COEF_W*i +: COEF_W]);
      t0_d[COEF_W*i +: COEF_W] = rd_data[COEF_W*i +: COEF_W]
                                 - (p2r_hi(rd_data[COEF_W*i +: COEF_W]) <<< D);
    end
  end

  // Stage 2: registered results and write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      t1_q      <= '0;
      t0_q      <= '0;
    end else begin
      wr_en_q <= s1_valid_q;
      if (s1_valid_q) begin
        wr_addr_q <= s1_addr_q;
        t1_q      <= t1_d;
        t0_q      <= t0_d;
      end
    end
  end

  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign t1_data = t1_q;
  assign t0_data = t0_q;

`ifdef P2R_RANGE_CHECK_EN
  localparam logic signed [COEF_W-1:0] QMOD = COEF_W'(8380417);
  logic range_q;
  logic lane_bad;

  always_comb begin
    lane_bad = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if ($signed(rd_data[COEF_W*i +: COEF_W]) < 0 ||
          $signed(rd_data[COEF_W*i +: COEF_W]) >= QMOD)
        lane_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_ok)              range_q <= 1'b0;
    else if (s1_valid_q && lane_bad)  range_q <= 1'b1;
  end

  assign range_err = range_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_polyveck_power2round_seq.sv
// Scoreboard bench for polyveck_power2round_seq: directed passes, mid-pass start/reset, optional range flag.
module tb_polyveck_power2round_seq;
  localparam int K = 6, N = 256, LANES = 4, CW = 32, D = 13, AW = 9;
  localparam int W = K * N / LANES;
  localparam int Q = 8380417;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [LANES*CW-1:0] rd_data = '0, t1_data, t0_data;
`ifdef P2R_RANGE_CHECK_EN
  logic range_err;
`endif

  polyveck_power2round_seq #(.K(K), .N(N), .LANES(LANES), .COEF_W(CW), .D(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .t1_data(t1_data), .t0_data(t0_data)
`ifdef P2R_RANGE_CHECK_EN
    , .range_err(range_err)
`endif
  );

  always #5 clk = ~clk;

  logic [LANES*CW-1:0] mem [W];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0]       addr;
    logic [LANES*CW-1:0] a;
    logic [LANES*CW-1:0] t1;
    logic [LANES*CW-1:0] t0;
  } exp_t;
  exp_t sbq[$];

  int n_chk = 0, n_pass = 0;
  int c0 = -100000;
  int abort_rel = 0;
  int rerr_rise = -1;
  bit mon_en = 1'b0;

  int tab_a  [12] = '{0, 4096, 4097, 8380416, 8191, 8192, 12288, 12289, 4095, 1, 8380415, 8376320};
  int tab_t1 [12] = '{0, 0, 1, 1023, 1, 1, 1, 2, 0, 0, 1023, 1022};
  int tab_t0 [12] = '{0, 4096, -4095, 0, -1, 0, 4096, -4095, 4095, 1, -1, 4096};

  task automatic chk(input string nm, input logic [LANES*CW-1:0] act, input logic [LANES*CW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Centered remainder mod 2^13, then the high part from the exact difference.
  task automatic ref_p2r(input int a, output int a1, output int a0);
    a0 = a & 8191;
    if (a0 > 4096) a0 -= 8192;
    a1 = (a - a0) >>> 13;
  endtask

  task automatic load_pass(input int mode, input bit inj);
    for (int n = 0; n < W; n++) begin
      exp_t e;
      e.addr = AW'(n);
      for (int i = 0; i < LANES; i++) begin
        int a, a1, a0, idx;
        idx = (n * LANES + i) % 12;
        case (mode)
          0: begin a = n; a1 = 0; a0 = n; end
          1: begin a = tab_a[idx]; a1 = tab_t1[idx]; a0 = tab_t0[idx]; end
          default: begin
            a = int'($urandom_range(0, Q - 1));
            if (inj && n == 50 && i == 2) a = -1;
            ref_p2r(a, a1, a0);
          end
        endcase
        e.a[CW*i +: CW]  = a;
        e.t1[CW*i +: CW] = a1;
        e.t0[CW*i +: CW] = a0;
      end
      mem[n] = e.a;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_rel(input int r);
    while (cyc - c0 < r) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic start_pass();
    abort_rel = 0;
    c0 = cyc;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    int r;
    bit ab, erd, ewr, ebusy, edone, ok;
    exp_t e;
    if (mon_en) begin
      r = cyc - c0;
      ab = (abort_rel > 0) && (r > abort_rel);
      erd   = !ab && r >= 1 && r <= W;
      ewr   = !ab && r >= 3 && r <= W + 2;
      ebusy = !ab && r >= 1 && r <= W + 2;
      edone = !ab && r == W + 3;
      chk("strobes{rd,wr,busy,done}", {rd_en, wr_en, busy, done}, {erd, ewr, ebusy, edone});
      if (erd) chk("rd_addr", rd_addr, r - 1);
      if (abort_rel > 0 && r == abort_rel + 1) begin
        chk("rst_t1", t1_data, '0);
        chk("rst_t0", t0_data, '0);
        chk("rst_addr", {rd_addr, wr_addr}, '0);
      end
`ifdef P2R_RANGE_CHECK_EN
      chk("range_err", range_err, (rerr_rise >= 0 && r >= rerr_rise));
`endif
      if (wr_en) begin
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL sb_underflow: write at addr %0d, expected no write", wr_addr);
        end else begin
          e = sbq.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("t1_data", t1_data, e.t1);
          chk("t0_data", t0_data, e.t0);
          ok = 1'b1;
          for (int i = 0; i < LANES; i++)
            if ($signed(t1_data[CW*i +: CW]) * 8192 + $signed(t0_data[CW*i +: CW])
                != $signed(e.a[CW*i +: CW])) ok = 1'b0;
          chk("identity", ok, 1'b1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_t1", t1_data, '0);
    chk("reset_t0", t0_data, '0);
    chk("reset_strobes", {busy, done, rd_en, wr_en, rd_addr, wr_addr}, '0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (3) begin @(negedge clk); #1; end

    // Ramp pattern, ignored mid-pass start, back-to-back restart after done.
    load_pass(0, 1'b0);
    start_pass();
    wait_rel(100);
    start = 1'b1; @(negedge clk); #1; start = 1'b0;
    wait_rel(W + 4);
    chk("sb_drained_1", sbq.size(), 0);

    load_pass(1, 1'b0);
    start_pass();
    wait_rel(W + 4);
    chk("sb_drained_2", sbq.size(), 0);

    // Reset in cycle 200 abandons the pass.
    load_pass(1, 1'b0);
    start_pass();
    wait_rel(200);
    rst = 1'b1;
    abort_rel = 200;
    @(negedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    wait_rel(230);

    load_pass(2, 1'b0);
    start_pass();
    wait_rel(W + 4);
    chk("sb_drained_4", sbq.size(), 0);

`ifdef P2R_RANGE_CHECK_EN
    load_pass(2, 1'b1);
    rerr_rise = 3 + 50;
    start_pass();
    wait_rel(W + 10);
    rerr_rise = -1;
    load_pass(0, 1'b0);
    start_pass();
    wait_rel(W + 4);
    chk("sb_drained_6", sbq.size(), 0);
`endif

    repeat (3) begin @(negedge clk); #1; end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
